// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two write-back lanes and the two regfile write ports
// seen by the write-back arbiter.
interface regfile_wb_arbiter_if #(
  parameter int WIDTH = 32
);
  // Upstream write-back lanes (lane1 is the younger one)
  logic             wb0_valid_i;
  logic [4:0]       wb0_addr_i;
  logic [WIDTH-1:0] wb0_data_i;
  logic             wb1_valid_i;
  logic [4:0]       wb1_addr_i;
  logic [WIDTH-1:0] wb1_data_i;
  logic             wb_ready_o;

  // Regfile write ports: port0 serves the even bank, port1 the odd bank
  logic [4:0]       wa0_o;
  logic             we0_o;
  logic [WIDTH-1:0] wd0_o;
  logic [4:0]       wa1_o;
  logic             we1_o;
  logic [WIDTH-1:0] wd1_o;
  logic             conflict_i;

  // Hazard/status towards the issue stage
  logic [31:0]      pending_o;
  logic             idle_o;

  // Arbiter side
  modport slave (
    input  wb0_valid_i, wb0_addr_i, wb0_data_i,
    input  wb1_valid_i, wb1_addr_i, wb1_data_i,
    input  conflict_i,
    output wb_ready_o,
    output wa0_o, we0_o, wd0_o,
    output wa1_o, we1_o, wd1_o,
    output pending_o, idle_o
  );

  // Environment side (write-back stage plus regfile)
  modport master (
    output wb0_valid_i, wb0_addr_i, wb0_data_i,
    output wb1_valid_i, wb1_addr_i, wb1_data_i,
    output conflict_i,
    input  wb_ready_o,
    input  wa0_o, we0_o, wd0_o,
    input  wa1_o, we1_o, wd1_o,
    input  pending_o, idle_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter in front of the even/odd banked register file.
// Two lanes in, one write per bank out per cycle. Writes that cannot be
// issued immediately wait in a per-bank FIFO; a register always maps to
// the same bank, so per-register write order is preserved.
module regfile_wb_arbiter #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  typedef struct packed {
    logic [4:0]       addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  // Per-bank FIFO storage and bookkeeping (index = bank = addr[0])
  wr_t  mem [2][DEPTH];
  ptr_t rd_ptr [2];
  ptr_t wr_ptr [2];
  cnt_t cnt    [2];

  logic       ready;
  logic       acc0, acc1;
  logic       keep0, keep1;
  wr_t        lane0, lane1;
  logic [1:0] hit0, hit1;

  logic [1:0] issue;
  logic [1:0] pop;
  wr_t        issue_wr [2];
  logic [1:0] push_n   [2];
  wr_t        push_a   [2];
  wr_t        push_b   [2];
  logic [31:0] pending;

  // Ready depends on registered counts only; at most one net push per bank
  // per cycle keeps a FIFO at DEPTH-1 from overflowing.
  assign ready = (cnt[0] < cnt_t'(DEPTH)) && (cnt[1] < cnt_t'(DEPTH));

  // A lane is taken only out of reset so a held request cannot fire a write
  // enable while rst_n is low.
  assign acc0 = bus.wb0_valid_i && ready && rst_n;
  assign acc1 = bus.wb1_valid_i && ready && rst_n;

  // r0 writes vanish; a same-address pair keeps only the younger lane1 value.
  assign keep0 = acc0 && !(DROP_R0 && (bus.wb0_addr_i == 5'd0))
                      && !(acc1 && (bus.wb0_addr_i == bus.wb1_addr_i));
  assign keep1 = acc1 && !(DROP_R0 && (bus.wb1_addr_i == 5'd0));

  assign lane0 = '{addr: bus.wb0_addr_i, data: bus.wb0_data_i};
  assign lane1 = '{addr: bus.wb1_addr_i, data: bus.wb1_data_i};

  // Route each surviving lane to its bank
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    hit0 = '0;
    hit1 = '0;
    hit0[lane0.addr[0]] = keep0;
    hit1[lane1.addr[0]] = keep1;
  end

  // Per-bank issue selection: FIFO head first, then incoming in age order;
  // whatever is not issued is pushed, lane0 ahead of lane1.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      issue[b]    = 1'b0;
      pop[b]      = 1'b0;
      issue_wr[b] = '0;
      push_n[b]   = 2'd0;
      push_a[b]   = '0;
      push_b[b]   = '0;
      if (cnt[b] != '0) begin
        issue[b]    = 1'b1;
        pop[b]      = 1'b1;
        issue_wr[b] = mem[b][rd_ptr[b]];
        if (hit0[b] && hit1[b]) begin
          push_a[b] = lane0;
          push_b[b] = lane1;
          push_n[b] = 2'd2;
        end else if (hit0[b]) begin
          push_a[b] = lane0;
          push_n[b] = 2'd1;
        end else if (hit1[b]) begin
          push_a[b] = lane1;
          push_n[b] = 2'd1;
        end
      end else if (hit0[b]) begin
        issue[b]    = 1'b1;
        issue_wr[b] = lane0;
        if (hit1[b]) begin
          push_a[b] = lane1;
          push_n[b] = 2'd1;
        end
      end else if (hit1[b]) begin
        issue[b]    = 1'b1;
        issue_wr[b] = lane1;
      end
    end
  end

  // FIFO pointers and occupancy
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        rd_ptr[b] <= '0;
        wr_ptr[b] <= '0;
        cnt[b]    <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        wr_ptr[b] <= wr_ptr[b] + ptr_t'(push_n[b]);
        rd_ptr[b] <= rd_ptr[b] + ptr_t'(pop[b]);
        cnt[b]    <= cnt[b] + cnt_t'(push_n[b]) - cnt_t'(pop[b]);
      end
    end
  end

  // FIFO storage writes, up to two consecutive slots per bank per cycle
  // NOTE: storage is deliberately not reset; the counts decide which slots are
  // live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (push_n[b] != 2'd0) mem[b][wr_ptr[b]] <= push_a[b];
      if (push_n[b] == 2'd2) mem[b][wr_ptr[b] + ptr_t'(1)] <= push_b[b];
    end
  end

  // Scoreboard bits: every live FIFO entry marks its destination register,
  // including the head that is issuing this cycle.
  always_comb begin
    pending = '0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_t'(i) < cnt[b]) pending[mem[b][rd_ptr[b] + ptr_t'(i)].addr] = 1'b1;
      end
    end
  end

  assign bus.wb_ready_o = ready;
  assign bus.we0_o      = issue[0];
  assign bus.wa0_o      = issue_wr[0].addr;
  assign bus.wd0_o      = issue_wr[0].data;
  assign bus.we1_o      = issue[1];
  assign bus.wa1_o      = issue_wr[1].addr;
  assign bus.wd1_o      = issue_wr[1].data;
  assign bus.pending_o  = pending;
  assign bus.idle_o     = (cnt[0] == '0) && (cnt[1] == '0);

  // Structural invariants of the banked steering
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!bus.conflict_i || !(bus.we0_o && bus.we1_o));
      assert (!bus.we0_o || !bus.wa0_o[0]);
      assert (!bus.we1_o || bus.wa1_o[0]);
      for (int b = 0; b < 2; b++) begin
        assert (!((push_n[b] != 2'd0) && (cnt[b] == cnt_t'(DEPTH))));
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised scoreboard bench for regfile_wb_arbiter. The reference model
// treats each bank as a plain queue of writes: accepted requests are
// appended in age order and the front of each non-empty queue is written
// that cycle.
module tb_regfile_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_wr_t;

  typedef struct {
    int          cyc;
    logic        ready;
    logic [31:0] pending;
    logic        idle;
  } exp_st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.WIDTH(WIDTH)) bus ();

  regfile_wb_arbiter #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DROP_R0(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // The regfile raises conflict only for two same-bank writes
  assign bus.conflict_i = bus.we0_o && bus.we1_o && (bus.wa0_o[0] == bus.wa1_o[0]);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  req_t    mq0 [$];
  req_t    mq1 [$];
  exp_wr_t ew0_q [$];
  exp_wr_t ew1_q [$];
  exp_st_t st_q [$];

  logic [31:0] model_rf [32] = '{default: '0};
  logic [31:0] dut_rf   [32] = '{default: '0};

  always @(posedge clk) cyc++;

  // Architectural register file as written by the DUT ports
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.we0_o) dut_rf[bus.wa0_o] <= bus.wd0_o;
      if (bus.we1_o) dut_rf[bus.wa1_o] <= bus.wd1_o;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus plus the matching model step
  task automatic do_cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                          output logic accepted);
    logic        rdy;
    logic [31:0] pend;
    logic        k0, k1;
    req_t        r;
    @(posedge clk);
    #1;
    bus.wb0_valid_i = v0;
    bus.wb0_addr_i  = a0;
    bus.wb0_data_i  = d0;
    bus.wb1_valid_i = v1;
    bus.wb1_addr_i  = a1;
    bus.wb1_data_i  = d1;

    rdy  = (mq0.size() < DEPTH) && (mq1.size() < DEPTH);
    pend = '0;
    foreach (mq0[i]) pend[mq0[i].addr] = 1'b1;
    foreach (mq1[i]) pend[mq1[i].addr] = 1'b1;
    st_q.push_back('{cyc: cyc, ready: rdy, pending: pend,
                     idle: (mq0.size() == 0) && (mq1.size() == 0)});
    accepted = rdy;

    if (rdy) begin
      k0 = v0 && (a0 != 5'd0) && !(v1 && (a0 == a1));
      k1 = v1 && (a1 != 5'd0);
      if (k0) begin
        r = '{addr: a0, data: d0};
        if (a0[0]) mq1.push_back(r); else mq0.push_back(r);
      end
      if (k1) begin
        r = '{addr: a1, data: d1};
        if (a1[0]) mq1.push_back(r); else mq0.push_back(r);
      end
    end

    if (mq0.size() > 0) begin
      r = mq0.pop_front();
      model_rf[r.addr] = r.data;
      ew0_q.push_back('{cyc: cyc, addr: r.addr, data: r.data});
    end
    if (mq1.size() > 0) begin
      r = mq1.pop_front();
      model_rf[r.addr] = r.data;
      ew1_q.push_back('{cyc: cyc, addr: r.addr, data: r.data});
    end
  endtask

  // Present a pair and hold it until accepted, as upstream does
  task automatic send(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 16 && !acc; t++) do_cycle(v0, a0, d0, v1, a1, d1, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: request not accepted within 16 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) do_cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, acc);
  endtask

  // Monitor: compares DUT outputs against what the model queued for this cycle
  always @(negedge clk) begin
    exp_st_t s;
    exp_wr_t w;
    if (!rst_n) begin
      check("rst_we0",     bus.we0_o,      1'b0);
      check("rst_we1",     bus.we1_o,      1'b0);
      check("rst_pending", bus.pending_o,  32'h0);
      check("rst_ready",   bus.wb_ready_o, 1'b1);
      check("rst_idle",    bus.idle_o,     1'b1);
    end else if (st_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL status_missing: no expected status for cycle %0d", cyc);
    end else begin
      s = st_q.pop_front();
      check("status_cycle", 64'(s.cyc), 64'(cyc));
      check("ready",   bus.wb_ready_o, s.ready);
      check("pending", bus.pending_o,  s.pending);
      check("idle",    bus.idle_o,     s.idle);
      if (ew0_q.size() > 0 && ew0_q[0].cyc == cyc) begin
        w = ew0_q.pop_front();
        check("we0", bus.we0_o, 1'b1);
        check("wa0", bus.wa0_o, w.addr);
        check("wd0", bus.wd0_o, w.data);
      end else begin
        check("we0_idle", bus.we0_o, 1'b0);
      end
      if (ew1_q.size() > 0 && ew1_q[0].cyc == cyc) begin
        w = ew1_q.pop_front();
        check("we1", bus.we1_o, 1'b1);
        check("wa1", bus.wa1_o, w.addr);
        check("wd1", bus.wd1_o, w.data);
      end else begin
        check("we1_idle", bus.we1_o, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ra0, ra1;
    logic        rv0, rv1;

    bus.wb0_valid_i = 1'b0;
    bus.wb0_addr_i  = '0;
    bus.wb0_data_i  = '0;
    bus.wb1_valid_i = 1'b0;
    bus.wb1_addr_i  = '0;
    bus.wb1_data_i  = '0;

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Opposite banks issue together at zero latency
    send(1'b1, 5'd4, 32'hA5, 1'b1, 5'd7, 32'h3C);
    idle(1);

    // Same bank: second write queued for one cycle
    send(1'b1, 5'd2, 32'h11, 1'b1, 5'd6, 32'h22);
    idle(2);

    // Same register: younger lane wins
    send(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
    idle(1);

    // r0 writes disappear
    send(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    idle(1);

    // Even pairs every cycle until back-pressure, repeated registers
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 5'(8 + 4 * (i % 3)), 32'h100 + 32'(i), 1'b1, 5'(10 + 4 * (i % 2)), 32'h200 + 32'(i));
    end
    idle(2 * DEPTH + 2);

    // Reset with three entries queued in the even bank
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 5'(16 + 2 * i), 32'h300 + 32'(i), 1'b1, 5'(22 + 2 * i), 32'h400 + 32'(i));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.wb0_valid_i = 1'b1;
    bus.wb0_addr_i  = 5'd12;
    bus.wb1_valid_i = 1'b1;
    bus.wb1_addr_i  = 5'd13;
    mq0.delete();
    mq1.delete();
    repeat (2) @(negedge clk);
    bus.wb0_valid_i = 1'b0;
    bus.wb1_valid_i = 1'b0;
    #2 rst_n = 1'b1;
    send(1'b1, 5'd4, 32'hBEEF, 1'b1, 5'd9, 32'hCAFE);
    idle(1);

    // Randomised traffic biased towards a few registers for collisions
    for (int n = 0; n < 300; n++) begin
      rv0 = ($urandom_range(0, 3) != 0);
      rv1 = ($urandom_range(0, 3) != 0);
      ra0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0) ra1 = {ra1[4:1], ra0[0]};
      send(rv0, ra0, $urandom(), rv1, ra1, $urandom());
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(2 * DEPTH + 2);

    @(negedge clk);
    #1;
    check("drain_port0", 64'(ew0_q.size()), 64'd0);
    check("drain_port1", 64'(ew1_q.size()), 64'd0);
    check("drain_status", 64'(st_q.size()), 64'd0);
    for (int r = 0; r < 32; r++) check($sformatf("rf_r%0d", r), dut_rf[r], model_rf[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
